seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one 4-bit-to-7-segment decoder among N_DIGITS common-anode digits. Each frame it steps through the digits. Every digit slot starts with a blanking gap to suppress ghosting, then drives that digit's nibble and decimal point to the decoder. New display data arrives over a valid/ready handshake into a pending buffer, and is committed only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clk cycles per digit slot (>= 4)
BLANK_CYC, 16, blanking cycles at the start of each slot (1 <= BLANK_CYC < PRESCALE)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  1 = scan; 0 = display dark
load_valid  in  1  data_in/dp_in valid
load_ready  out  1  pending buffer empty; load accepted when load_valid & load_ready
data_in  in  4*N_DIGITS  digit nibbles; digit i = data_in[4i+3:4i]
dp_in  in  N_DIGITS  decimal point per digit
seg_val  out  4  nibble to the decoder
seg_dp  out  1  decimal point to the decoder
an_n  out  N_DIGITS  digit enables, active-low
frame_end  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Storage: active buffer (displayed), pending buffer plus pending_full flag. load_ready = ~pending_full (combinational).
- Reset (reset=0, async):
  - state IDLE; slot counter cnt=0; digit index idx=0.
  - Active and pending buffers cleared; pending_full=0.
  - an_n all 1; seg_val=0; seg_dp=0; frame_end=0.
- All outputs except load_ready are registered.
- States:
  - IDLE: an_n all 1; cnt=0; idx=0. If pending_full, transfer pending to active and clear pending_full. enable=1 -> BLANK.
  - BLANK: an_n all 1; seg_val/seg_dp = active digit idx. Lasts BLANK_CYC cycles (cnt 0..BLANK_CYC-1), then -> SHOW.
  - SHOW: an_n[idx]=0, all other bits 1; seg_val/seg_dp = active digit idx. Lasts cnt BLANK_CYC..PRESCALE-1.
  - End of SHOW slot: cnt wraps to 0, -> BLANK, idx = (idx+1) mod N_DIGITS.
- Every slot is exactly PRESCALE cycles; a frame is N_DIGITS*PRESCALE cycles.
- cnt width = $clog2(PRESCALE); idx width = $clog2(N_DIGITS), minimum 1.
- enable=0 in any state: IDLE on the next edge, an_n all 1, cnt and idx cleared. The partial frame is abandoned. Re-enable always restarts at idx 0 with a BLANK period.
- frame_end = 1 while state=SHOW, idx=N_DIGITS-1 and cnt=PRESCALE-1.
- Commit at that edge: if pending_full, active <= pending and pending_full <= 0. The new data is first displayed in the idx 0 slot of the next frame.
- Load acceptance: when load_valid & load_ready, pending <= {data_in, dp_in} and pending_full <= 1 on the same edge.
- Load and commit in the same cycle cannot collide: commit needs pending_full=1, which forces load_ready=0.
- load_valid while load_ready=0 is ignored; the pending contents are unchanged.
- A load accepted while in IDLE is committed on the following edge.

Test Plan (N_DIGITS=4, PRESCALE=8, BLANK_CYC=2):
1. reset=0 held 3 cycles, enable=1, load_valid=1 -> an_n=4'b1111, seg_val=0, seg_dp=0, frame_end=0, load_ready=1 throughout; no state change.
2. Release reset, load data_in=16'h1234, dp_in=4'b0001 in IDLE, then enable=1 -> per frame seg_val 4,3,2,1. Each digit: an_n=1111 for 2 cycles, then an_n[i]=0 for 6 cycles. seg_dp=1 only for digit 0. frame_end pulses every 32 cycles.
3. Mid-frame (digit 1 showing), load 16'hABCD -> load_ready drops next cycle. Remaining digits of the current frame stay 2,1. After frame_end, digits D,C,B,A are shown and load_ready=1.
4. Second load_valid (16'h5555) while load_ready=0 -> ignored; the next frame still shows D,C,B,A.
5. enable=0 during the digit 2 SHOW -> an_n=1111 next cycle. Re-enable after 5 cycles -> 2 blank cycles, then an_n=4'b1110 showing digit 0.
6. Async reset=0 mid-SHOW (not on a clk edge) -> an_n=1111 immediately, seg_val=0, load_ready=1. After release and enable=1, all digits show 0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake for the seg7 scan controller: display data
// offered by a producer and accepted into the pending buffer.
interface seg7_scan_ctrl_if #(
    parameter int N_DIGITS = 4
) ();
    logic                      load_valid;
    logic                      load_ready;
    logic [4*N_DIGITS-1:0]     data_in;
    logic [N_DIGITS-1:0]       dp_in;

    modport master (
        output load_valid,
        output data_in,
        output dp_in,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  data_in,
        input  dp_in,
        output load_ready
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking gaps
// and frame-synchronous commit of double-buffered display data.
module seg7_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    seg7_scan_ctrl_if.slave     load,
    output logic [3:0]          seg_val,
    output logic                seg_dp,
    output logic [N_DIGITS-1:0] an_n,
    output logic                frame_end
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_END  = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [4*N_DIGITS-1:0] r_act_data;
    logic [N_DIGITS-1:0]   r_act_dp;
    logic [4*N_DIGITS-1:0] r_pend_data;
    logic [N_DIGITS-1:0]   r_pend_dp;
    logic                  r_pend_full;
    logic [3:0]            r_seg_val;
    logic                  r_seg_dp;
    logic [N_DIGITS-1:0]   r_an_n;
    logic                  r_frame_end;

    state_t                w_state_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic                  w_fe_now;
    logic                  w_commit;
    logic                  w_load;
    logic [4*N_DIGITS-1:0] w_act_data_nxt;
    logic [N_DIGITS-1:0]   w_act_dp_nxt;
    logic [3:0]            w_digs [N_DIGITS];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
                S_BLANK: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == BLK_END)
                        w_state_nxt = S_SHOW;
                end
                S_SHOW: begin
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = S_BLANK;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Commit only while dark or on the last cycle of a frame
    assign w_fe_now = (r_state == S_SHOW) && (r_idx == LAST_IDX)
                   && (r_cnt == LAST_CNT);
    assign w_commit = r_pend_full && ((r_state == S_IDLE) || w_fe_now);
    assign w_load   = load.load_valid && !r_pend_full;

    assign w_act_data_nxt = w_commit ? r_pend_data : r_act_data;
    assign w_act_dp_nxt   = w_commit ? r_pend_dp   : r_act_dp;

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++)
            w_digs[i] = w_act_data_nxt[4*i +: 4];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_full <= 1'b0;
            r_seg_val   <= 4'd0;
            r_seg_dp    <= 1'b0;
            r_an_n      <= '1;
            r_frame_end <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;

            if (w_commit) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_pend_full <= 1'b0;
            end else if (w_load) begin
                r_pend_data <= load.data_in;
                r_pend_dp   <= load.dp_in;
                r_pend_full <= 1'b1;
            end

            // Outputs track the state being entered so they line up with it
            r_an_n <= '1;
            if (w_state_nxt == S_SHOW)
                r_an_n[w_idx_nxt] <= 1'b0;

            if (w_state_nxt == S_IDLE) begin
                r_seg_val <= 4'd0;
                r_seg_dp  <= 1'b0;
            end else begin
                r_seg_val <= w_digs[w_idx_nxt];
                r_seg_dp  <= w_act_dp_nxt[w_idx_nxt];
            end

            r_frame_end <= (w_state_nxt == S_SHOW)
                        && (w_idx_nxt == LAST_IDX)
                        && (w_cnt_nxt == LAST_CNT);
        end
    end

    assign load.load_ready = !r_pend_full;
    assign seg_val         = r_seg_val;
    assign seg_dp          = r_seg_dp;
    assign an_n            = r_an_n;
    assign frame_end       = r_frame_end;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: slot expectations queued by the
// stimulus, popped by a monitor at the start of every SHOW period.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] val;
        logic       dp;
    } slot_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    seg_val;
    logic          seg_dp;
    logic [ND-1:0] an_n;
    logic          frame_end;

    seg7_scan_ctrl_if #(.N_DIGITS(ND)) ld_if ();

    seg7_scan_ctrl #(
        .N_DIGITS  (ND),
        .PRESCALE  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (ld_if.slave),
        .seg_val   (seg_val),
        .seg_dp    (seg_dp),
        .an_n      (an_n),
        .frame_end (frame_end)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    run    = 0;
    int    fe_a;
    int    fe_b;
    int    fe_c;
    bit    abort_ok = 1'b0;
    slot_t sb_q[$];
    slot_t mon_e;
    logic [3:0] prev_an = 4'hF;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                              input int n);
        slot_t s;
        for (int i = 0; i < n; i++) begin
            s.an  = ~(4'b0001 << i);
            s.val = d[4*i +: 4];
            s.dp  = p[i];
            sb_q.push_back(s);
        end
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        int k = 0;
        while (an_n !== v && k < 100) begin
            tick();
            k++;
        end
        chk(nm, an_n, v);
    endtask

    task automatic wait_fe(input string nm);
        int k = 0;
        tick();
        while (frame_end !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk(nm, frame_end, 1);
    endtask

    // Monitor: each SHOW period must match the queued slot and last 6 cycles
    always @(negedge clk) begin
        if (an_n != 4'hF) begin
            if (prev_an == 4'hF) begin
                if (sb_q.size() == 0) begin
                    chk("slot queue", an_n, 4'hF);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("slot an_n", an_n, mon_e.an);
                    chk("slot seg_val", seg_val, mon_e.val);
                    chk("slot seg_dp", seg_dp, mon_e.dp);
                end
                run = 1;
            end else begin
                run++;
            end
        end else if (prev_an != 4'hF) begin
            if (abort_ok) abort_ok = 1'b0;
            else chk("show length", run, 6);
        end
        prev_an = an_n;
    end

    initial begin
        reset            = 1'b0;
        enable           = 1'b1;
        ld_if.load_valid = 1'b1;
        ld_if.data_in    = 16'h9999;
        ld_if.dp_in      = 4'hF;

        repeat (3) begin
            tick();
            chk("rst an_n", an_n, 4'hF);
            chk("rst seg_val", seg_val, 0);
            chk("rst seg_dp", seg_dp, 0);
            chk("rst frame_end", frame_end, 0);
            chk("rst load_ready", ld_if.load_ready, 1);
        end

        reset         = 1'b1;
        enable        = 1'b0;
        ld_if.data_in = 16'h1234;
        ld_if.dp_in   = 4'b0001;
        tick();
        chk("idle load accepted", ld_if.load_ready, 0);
        ld_if.load_valid = 1'b0;
        tick();
        chk("idle commit", ld_if.load_ready, 1);
        chk("idle dark", an_n, 4'hF);

        push_frame(16'h1234, 4'b0001, 4);
        push_frame(16'h1234, 4'b0001, 4);
        enable = 1'b1;
        wait_fe("frame A end");
        fe_a = cyc;
        chk("fe on digit 3", an_n, 4'b0111);

        wait_an(4'b1101, "frame B digit 1");
        ld_if.load_valid = 1'b1;
        ld_if.data_in    = 16'hABCD;
        ld_if.dp_in      = 4'b1010;
        tick();
        chk("mid-frame load", ld_if.load_ready, 0);
        push_frame(16'hABCD, 4'b1010, 4);
        push_frame(16'hABCD, 4'b1010, 3);
        ld_if.data_in = 16'h5555;
        ld_if.dp_in   = 4'b0101;
        repeat (3) begin
            tick();
            chk("busy load_ready", ld_if.load_ready, 0);
        end
        ld_if.load_valid = 1'b0;

        wait_fe("frame B end");
        fe_b = cyc;
        chk("frame period B", fe_b - fe_a, 32);
        chk("ready at frame_end", ld_if.load_ready, 0);
        tick();
        chk("ready after commit", ld_if.load_ready, 1);
        chk("fe one cycle", frame_end, 0);

        wait_fe("frame C end");
        fe_c = cyc;
        chk("frame period C", fe_c - fe_b, 32);

        wait_an(4'b1011, "frame D digit 2");
        abort_ok = 1'b1;
        enable   = 1'b0;
        tick();
        chk("disable dark", an_n, 4'hF);
        chk("disable fe", frame_end, 0);
        repeat (4) begin
            tick();
            chk("disabled dark", an_n, 4'hF);
        end
        push_frame(16'hABCD, 4'b1010, 1);
        enable = 1'b1;
        tick();
        chk("reen blank 0", an_n, 4'hF);
        tick();
        chk("reen blank 1", an_n, 4'hF);
        tick();
        chk("reen show an_n", an_n, 4'b1110);
        chk("reen show val", seg_val, 4'hD);

        tick();
        tick();
        abort_ok = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async an_n", an_n, 4'hF);
        chk("async seg_val", seg_val, 0);
        chk("async load_ready", ld_if.load_ready, 1);
        push_frame(16'h0000, 4'b0000, 4);
        reset = 1'b1;

        begin
            int k = 0;
            while (sb_q.size() != 0 && k < 200) begin
                tick();
                k++;
            end
        end
        chk("scoreboard drained", sb_q.size(), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
